// File: rtl/branch_redirect_pkg.sv
//------------------------------------------------------------------------------
// Module      : branch_redirect_pkg
// Description : Shared constants, types and age helpers for the commit-side
//               branch redirect path (also consumed by fetch).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package branch_redirect_pkg;

    localparam int NBR      = 2;
    localparam int RV       = 64;
    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = 5;
    localparam int BDEC     = 4;
    localparam int LNBR     = (NBR > 1) ? $clog2(NBR) : 1;

    typedef logic [NCOMMIT-1:0]  kill_mask_t;
    typedef logic [LNCOMMIT-1:0] slot_t;

    typedef struct packed {
        logic [RV-2:0]   pc;
        logic            is_short;
        logic [BDEC-2:0] dec;
    } redirect_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } br_state_e;

    // Modular subtract: wraps naturally when slot < head.
    function automatic slot_t age_f(input slot_t slot, input slot_t head);
        return slot - head;
    endfunction

    function automatic kill_mask_t kill_mask_f(input slot_t win_age, input slot_t head);
        kill_mask_t m;
        m = '0;
        for (int s = 0; s < NCOMMIT; s++) begin
            m[s] = (age_f(slot_t'(s), head) > win_age);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_redirect_if.sv
//------------------------------------------------------------------------------
// Module      : branch_redirect_if
// Description : Branch-unit mispredict reports and fetch redirect handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_redirect_if;
    import branch_redirect_pkg::*;

    logic [NBR-1:0]            br_enable;
    logic [NBR*LNCOMMIT-1:0]   br_addr;
    logic [NBR*(RV-1)-1:0]     br_dest;
    logic [NBR-1:0]            br_short;
    logic [NBR*(BDEC-1)-1:0]   br_dec;

    logic                      redirect_valid;
    logic                      redirect_ready;
    logic [RV-2:0]             redirect_pc;
    logic                      redirect_short;
    logic [BDEC-2:0]           redirect_dec;

    modport master (
        output br_enable, br_addr, br_dest, br_short, br_dec, redirect_ready,
        input  redirect_valid, redirect_pc, redirect_short, redirect_dec
    );

    modport slave (
        input  br_enable, br_addr, br_dest, br_short, br_dec, redirect_ready,
        output redirect_valid, redirect_pc, redirect_short, redirect_dec
    );

endinterface

`default_nettype wire

// File: rtl/branch_redirect_sel.sv
//------------------------------------------------------------------------------
// Module      : br_oldest_sel
// Description : Combinational NBR-way minimum-age selector, lowest index wins ties.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module br_oldest_sel
    import branch_redirect_pkg::*;
(
    input  logic [NBR-1:0]          i_valid,
    input  logic [NBR*LNCOMMIT-1:0] i_age,
    output logic                    o_found,
    output logic [LNBR-1:0]         o_idx,
    output logic [LNCOMMIT-1:0]     o_age
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        o_age   = '0;
        // Strict less-than keeps the lower index on equal ages.
        for (int i = 0; i < NBR; i++) begin
            if (i_valid[i] && (!o_found || (i_age[i*LNCOMMIT +: LNCOMMIT] < o_age))) begin
                o_found = 1'b1;
                o_idx   = LNBR'(i);
                o_age   = i_age[i*LNCOMMIT +: LNCOMMIT];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_redirect.sv
//------------------------------------------------------------------------------
// Module      : branch_redirect
// Description : Keeps the oldest mispredicting branch, pulses a younger-slot kill
//               mask and holds a PC redirect toward fetch.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_redirect
    import branch_redirect_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LNCOMMIT-1:0] i_commit_head,
    input  logic                i_flush,
    output logic [NCOMMIT-1:0]  o_commit_kill,
    branch_redirect_if.slave    br_if
);

    br_state_e           r_state;
    br_state_e           w_state_nxt;
    slot_t               r_slot;
    redirect_t           r_payload;
    kill_mask_t          r_kill;
    kill_mask_t          r_filt;
    logic [1:0]          r_filt_cnt;

    kill_mask_t          w_filt;
    slot_t               w_pend_age;
    logic [NBR-1:0]      w_cand;
    logic [NBR*LNCOMMIT-1:0] w_ages;
    logic                w_win;
    logic [LNBR-1:0]     w_win_idx;
    slot_t               w_win_age;
    slot_t               w_win_slot;
    redirect_t           w_win_pay;
    kill_mask_t          w_kill_mask;
    logic                w_load;

    assign w_filt     = (r_filt_cnt != 2'd0) ? r_filt : '0;
    assign w_pend_age = age_f(r_slot, i_commit_head);

    always_comb begin
        w_cand = '0;
        w_ages = '0;
        for (int i = 0; i < NBR; i++) begin
            w_ages[i*LNCOMMIT +: LNCOMMIT] = age_f(br_if.br_addr[i*LNCOMMIT +: LNCOMMIT], i_commit_head);
            w_cand[i] = br_if.br_enable[i]
                      && !i_flush
                      && !w_filt[br_if.br_addr[i*LNCOMMIT +: LNCOMMIT]]
                      && ((r_state == ST_IDLE) || (w_ages[i*LNCOMMIT +: LNCOMMIT] < w_pend_age));
        end
    end

    br_oldest_sel u_sel (
        .i_valid (w_cand),
        .i_age   (w_ages),
        .o_found (w_win),
        .o_idx   (w_win_idx),
        .o_age   (w_win_age)
    );

    always_comb begin
        w_win_slot = '0;
        w_win_pay  = '0;
        for (int i = 0; i < NBR; i++) begin
            if (w_win_idx == LNBR'(i)) begin
                w_win_slot         = br_if.br_addr[i*LNCOMMIT +: LNCOMMIT];
                w_win_pay.pc       = br_if.br_dest[i*(RV-1) +: (RV-1)];
                w_win_pay.is_short = br_if.br_short[i];
                w_win_pay.dec      = br_if.br_dec[i*(BDEC-1) +: (BDEC-1)];
            end
        end
    end

    assign w_kill_mask = kill_mask_f(w_win_age, i_commit_head);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else if (w_win) begin
            w_state_nxt = ST_PEND;
            w_load      = 1'b1;
        end else if ((r_state == ST_PEND) && br_if.redirect_ready) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_slot     <= '0;
            r_payload  <= '0;
            r_kill     <= '0;
            r_filt     <= '0;
            r_filt_cnt <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_load ? w_kill_mask : '0;
            if (w_load) begin
                r_slot    <= w_win_slot;
                r_payload <= w_win_pay;
            end
            // Filter spans the pulse cycle plus the branch unit's two stages.
            if (i_flush) begin
                r_filt     <= '0;
                r_filt_cnt <= 2'd0;
            end else if (w_load) begin
                r_filt     <= w_kill_mask;
                r_filt_cnt <= 2'd3;
            end else if (r_filt_cnt != 2'd0) begin
                r_filt_cnt <= r_filt_cnt - 2'd1;
            end
        end
    end

    assign o_commit_kill         = r_kill;
    assign br_if.redirect_valid  = (r_state == ST_PEND);
    assign br_if.redirect_pc     = r_payload.pc;
    assign br_if.redirect_short  = r_payload.is_short;
    assign br_if.redirect_dec    = r_payload.dec;

endmodule

`default_nettype wire

// File: doc/branch_redirect.md
# branch_redirect

Commit-side collector for branch-unit mispredict reports. Each cycle it accepts `commit_br_*` reports from up to NBR branch units and keeps the oldest mispredict relative to the commit head. It pulses a `commit_kill` mask for every slot younger than that branch, then holds a PC redirect toward fetch under a valid/ready handshake. It closes the loop with the branch units, which consume `commit_kill`.

## Interface
- NBR, 2: number of branch units reporting
- RV, 64: register width; addresses are RV-1 bits (bit 0 implicit zero)
- NCOMMIT, 32: commit slots; power of two
- LNCOMMIT, 5: log2(NCOMMIT)
- BDEC, 4: width+1 of decode-lane field

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- br_enable  in  NBR  per-unit mispredict report valid (`commit_br_enable`)
- br_addr  in  NBR*LNCOMMIT  commit slot of reporting branch
- br_dest  in  NBR*(RV-1)  corrected target [RV-1:1]
- br_short  in  NBR  branch was 16-bit
- br_dec  in  NBR*(BDEC-1)  branch PC[BDEC-1:1]
- commit_head  in  LNCOMMIT  oldest uncommitted slot
- flush  in  1  trap/exception flush; drops pending redirect
- commit_kill  out  NCOMMIT  one-cycle kill pulse, bit per slot
- redirect_valid  out  1  redirect pending to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  RV-1  target [RV-1:1]
- redirect_short, redirect_dec  out  1, BDEC-1  copied from winning report

## Operation
- Age of slot s = (s - commit_head) mod NCOMMIT, LNCOMMIT-bit unsigned subtract; smaller is older.
- Filter: a report is discarded if its slot is set in the held kill filter. The filter is the last issued kill mask, held for 2 cycles after the pulse, covering the branch unit's 2-stage pipeline. It is also discarded if it is younger than or equal to the pending branch.
- Select: among surviving reports, the minimum age wins; ties (illegal) go to the lowest unit index.
- States: IDLE (no pending), PEND (redirect_valid=1, payload = pending branch).
- IDLE + winner → PEND. Latch slot/dest/short/dec, compute kill mask (bit i set iff age(i) > age(winner)), pulse commit_kill.
- PEND + older winner → stay PEND. Replace payload, new kill pulse. This applies even while redirect_ready=1: the handshake completes on the new payload, and the old one is dropped.
- PEND + redirect_ready, no winner → IDLE.
- flush (any state) → IDLE next cycle, no kill pulse. Reports in the same cycle are discarded, and the filter is cleared.
- Reset: commit_kill=0, redirect_valid=0, payload=0, filter=0, state IDLE, all asynchronous.

## Timing
- Report sampled at edge ending cycle N → commit_kill pulse and redirect_valid/payload visible in cycle N+1 (1-cycle latency, registered outputs).
- commit_kill high exactly one cycle per accepted winner. It is never asserted on the winning slot itself or on older slots.
- redirect payload changes while valid only when replaced by an older branch. Otherwise it is stable until the ready cycle.
- Handshake completes on the edge where valid&ready. Valid drops the next cycle unless a new winner is latched.
- Wrap-around: age arithmetic must be correct when branch slot < commit_head.

## Structure
- Shared package: `age_f(slot, head)` function, kill-mask width and NCOMMIT/LNCOMMIT constants, redirect payload struct (pc, short, dec), also used by fetch.
- One sub-module: `br_oldest_sel` (combinational NBR-way min-age selector with index tie-break). Everything else stays in `branch_redirect`.

## Test plan
- head=2, unit0 reports slot 5, dest 0x800 → N+1: commit_kill=0xFFFF_FFC3, redirect_valid=1, redirect_pc=0x800; ready=1 → IDLE at N+2.
- head=4, unit0 slot 10, unit1 slot 7 same cycle → winner slot 7, commit_kill=0xFFFF_FF0F, payload from unit1.
- head=30, unit0 slot 1, unit1 slot 31 → slot 31 wins, commit_kill=0x3FFF_FFFF (wrap).
- PEND on slot 9 (head 0), ready=0. Report slot 12 → ignored, no pulse. Report slot 6 → new pulse 0xFFFF_FF80, redirect_pc updates, valid stays 1.
- Report slot 3 one cycle after a kill mask containing slot 3 → discarded, no change.
- PEND, flush=1 → redirect_valid=0 next cycle, no kill. Reset low mid-PEND → all outputs 0 immediately, no clock edge needed.
